// File: rtl/qkd_pkg.sv
// qkd_pkg: shared definitions for the BB84 sifting stage.
//   - polarisation codes and basis encodings
//   - default frame geometry
//   - sift controller FSM state encoding
//   - sift_eval(): classifies one qubit position against both bases
package qkd_pkg;

    localparam int N_QUBITS_DEFAULT = 80;
    localparam int WORD_W_DEFAULT   = 8;

    // Polarisation codes carried in qubit[2i+1:2i]
    localparam logic [1:0] ZERO         = 2'b00;  // 0 deg
    localparam logic [1:0] NINETY       = 2'b01;  // 90 deg
    localparam logic [1:0] FORTYFIVE    = 2'b10;  // 45 deg
    localparam logic [1:0] ONETHREEFIVE = 2'b11;  // 135 deg

    // Basis encodings
    localparam logic RECT = 1'b0;
    localparam logic DIAG = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SCAN  = 2'b01,
        FLUSH = 2'b10,
        DRAIN = 2'b11
    } sift_state_e;

    typedef struct packed {
        logic matched;     // sender and receiver chose the same basis
        logic consistent;  // polarisation belongs to the sender's basis
        logic key_bit;     // bit value carried by the polarisation
    } sift_eval_t;

    // A rectilinear sender can only emit 0/90 deg, a diagonal one 45/135 deg;
    // anything else on a matched position indicates a corrupted qubit.
    function automatic sift_eval_t sift_eval(
        input logic [1:0] pol,
        input logic       s_basis,
        input logic       r_basis
    );
        sift_eval_t res;
        res.matched = (s_basis == r_basis);
        if (s_basis == RECT) begin
            res.consistent = (pol == ZERO) || (pol == NINETY);
        end else if (s_basis == DIAG) begin
            res.consistent = (pol == FORTYFIVE) || (pol == ONETHREEFIVE);
        end else begin
            res.consistent = 1'b0;
        end
        res.key_bit = (pol == NINETY) || (pol == ONETHREEFIVE);
        return res;
    endfunction

endpackage

// File: rtl/sift_bit_packer.sv
// sift_bit_packer: packs sifted key bits (LSB = earliest) into words and
// holds them in an output register behind a valid/ready handshake.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clr             clear accumulator and fill count (frame start)
//   bit_valid       a sifted bit is presented this cycle
//   bit_in          the sifted bit value
//   last_in         a word completed this cycle is the frame's last
//   flush           load the partial accumulator as the final word
//   fill            number of bits currently accumulated
//   word_done       this cycle's bit completes a full word
//   key_data/key_valid/key_ready/key_last/key_nbits  output word stream
module sift_bit_packer #(
    parameter int WORD_W  = 8,
    parameter int FILL_W  = $clog2(WORD_W),
    parameter int NBITS_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               bit_valid,
    input  logic               bit_in,
    input  logic               last_in,
    input  logic               flush,
    output logic [FILL_W-1:0]  fill,
    output logic               word_done,
    output logic [WORD_W-1:0]  key_data,
    output logic               key_valid,
    input  logic               key_ready,
    output logic               key_last,
    output logic [NBITS_W-1:0] key_nbits
);

    logic [WORD_W-2:0]  acc_q,   acc_d;
    logic [FILL_W-1:0]  fill_q,  fill_d;
    logic [WORD_W-1:0]  data_q,  data_d;
    logic               valid_q, valid_d;
    logic               last_q,  last_d;
    logic [NBITS_W-1:0] nbits_q, nbits_d;

    // The final bit of a word goes straight to the output register, so the
    // accumulator only ever needs WORD_W-1 bits.
    assign word_done = bit_valid && (fill_q == FILL_W'(WORD_W - 1));

    // Accumulator, fill counter and output register next-state.
    always_comb begin
        acc_d   = acc_q;
        fill_d  = fill_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        nbits_d = nbits_q;

        if (clr) begin
            acc_d  = '0;
            fill_d = '0;
        end else if (bit_valid) begin
            if (word_done) begin
                // Zeroing here keeps the unused upper bits of a later
                // partial word at zero.
                acc_d  = '0;
                fill_d = '0;
            end else begin
                acc_d[fill_q] = bit_in;
                fill_d        = fill_q + FILL_W'(1);
            end
        end else begin
            acc_d  = acc_q;
            fill_d = fill_q;
        end

        if (word_done) begin
            data_d  = {bit_in, acc_q};
            valid_d = 1'b1;
            last_d  = last_in;
            nbits_d = NBITS_W'(WORD_W);
        end else if (flush) begin
            data_d  = {1'b0, acc_q};
            valid_d = 1'b1;
            last_d  = 1'b1;
            nbits_d = NBITS_W'(fill_q);
        end else if (valid_q && key_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Packer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            fill_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            nbits_q <= '0;
        end else begin
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            nbits_q <= nbits_d;
        end
    end

    assign fill      = fill_q;
    assign key_data  = data_q;
    assign key_valid = valid_q;
    assign key_last  = last_q;
    assign key_nbits = nbits_q;

endmodule

// File: rtl/sift_controller.sv
// sift_controller: BB84 sifting sequencer. Accepts one frame of qubits and
// both basis vectors, scans one position per cycle, streams packed key
// words and reports per-frame sifted / inconsistent counts.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   frame_valid/frame_ready        frame handshake (ready only in IDLE)
//   qubit, sender_bases, receiver_bases   frame contents
//   key_data/key_valid/key_ready/key_last/key_nbits   key word stream
//   busy                           not IDLE
//   done                           one-cycle pulse in first IDLE cycle after a frame
//   sift_count, bad_count          live per-frame counters, held after done
module sift_controller
    import qkd_pkg::*;
#(
    parameter int N_QUBITS = N_QUBITS_DEFAULT,
    parameter int WORD_W   = WORD_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_valid,
    output logic                  frame_ready,
    input  logic [2*N_QUBITS-1:0] qubit,
    input  logic [N_QUBITS-1:0]   sender_bases,
    input  logic [N_QUBITS-1:0]   receiver_bases,
    output logic [WORD_W-1:0]     key_data,
    output logic                  key_valid,
    input  logic                  key_ready,
    output logic                  key_last,
    output logic [3:0]            key_nbits,
    output logic                  busy,
    output logic                  done,
    output logic [6:0]            sift_count,
    output logic [6:0]            bad_count
);

    localparam int IDX_W  = $clog2(N_QUBITS);
    localparam int FILL_W = $clog2(WORD_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_QUBITS - 1);

    sift_state_e           state_q, state_d;
    logic [IDX_W-1:0]      idx_q,   idx_d;
    logic [2*N_QUBITS-1:0] qubit_q, qubit_d;
    logic [N_QUBITS-1:0]   sb_q,    sb_d;
    logic [N_QUBITS-1:0]   rb_q,    rb_d;
    logic [6:0]            sift_q,  sift_d;
    logic [6:0]            bad_q,   bad_d;
    logic                  done_q,  done_d;

    logic                  accept;
    logic                  stall;
    logic                  proc_en;
    logic                  bit_valid;
    logic                  bad_hit;
    logic                  clr;
    logic                  flush;
    logic                  last_word;
    logic                  word_done;
    logic [FILL_W-1:0]     fill;
    sift_eval_t            cur_eval;

    assign accept = (state_q == IDLE) && frame_valid;

    // Any word waiting on the consumer freezes the scan, even if the
    // current position would not produce a bit.
    assign stall   = key_valid && !key_ready;
    assign proc_en = (state_q == SCAN) && !stall;

    assign cur_eval  = sift_eval(qubit_q[{idx_q, 1'b0} +: 2], sb_q[idx_q], rb_q[idx_q]);
    assign bit_valid = proc_en && cur_eval.matched && cur_eval.consistent;
    assign bad_hit   = proc_en && cur_eval.matched && !cur_eval.consistent;

    // FSM next-state, frame latches, index and packer control.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        qubit_d   = qubit_q;
        sb_d      = sb_q;
        rb_d      = rb_q;
        done_d    = 1'b0;
        clr       = 1'b0;
        flush     = 1'b0;
        last_word = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    qubit_d = qubit;
                    sb_d    = sender_bases;
                    rb_d    = receiver_bases;
                    idx_d   = '0;
                    clr     = 1'b1;
                    state_d = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (!proc_en) begin
                    state_d = SCAN;
                end else if (idx_q == LAST_IDX) begin
                    if (word_done) begin
                        last_word = 1'b1;
                        state_d   = DRAIN;
                    end else if (!bit_valid && (fill == FILL_W'(0))) begin
                        // Nothing left to flush: finish without a FLUSH cycle.
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = FLUSH;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            FLUSH: begin
                if (stall) begin
                    state_d = FLUSH;
                end else if (fill == FILL_W'(0)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    flush   = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (key_valid && key_ready) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Per-frame statistics: cleared on accept, live during the scan.
    always_comb begin
        sift_d = sift_q;
        bad_d  = bad_q;
        if (accept) begin
            sift_d = 7'd0;
            bad_d  = 7'd0;
        end else begin
            if (bit_valid) begin
                sift_d = sift_q + 7'd1;
            end else begin
                sift_d = sift_q;
            end
            if (bad_hit) begin
                bad_d = bad_q + 7'd1;
            end else begin
                bad_d = bad_q;
            end
        end
    end

    // Controller state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            qubit_q <= '0;
            sb_q    <= '0;
            rb_q    <= '0;
            sift_q  <= 7'd0;
            bad_q   <= 7'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            qubit_q <= qubit_d;
            sb_q    <= sb_d;
            rb_q    <= rb_d;
            sift_q  <= sift_d;
            bad_q   <= bad_d;
            done_q  <= done_d;
        end
    end

    sift_bit_packer #(
        .WORD_W  (WORD_W),
        .FILL_W  (FILL_W),
        .NBITS_W (4)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .bit_valid (bit_valid),
        .bit_in    (cur_eval.key_bit),
        .last_in   (last_word),
        .flush     (flush),
        .fill      (fill),
        .word_done (word_done),
        .key_data  (key_data),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_last  (key_last),
        .key_nbits (key_nbits)
    );

    assign frame_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign sift_count  = sift_q;
    assign bad_count   = bad_q;

endmodule

// File: tb/tb_sift_controller.sv
module tb_sift_controller;

    localparam int NQ = 80;

    logic          clk;
    logic          rst;
    logic          frame_valid;
    logic          frame_ready;
    logic [2*NQ-1:0] qubit;
    logic [NQ-1:0] sender_bases;
    logic [NQ-1:0] receiver_bases;
    logic [7:0]    key_data;
    logic          key_valid;
    logic          key_ready;
    logic          key_last;
    logic [3:0]    key_nbits;
    logic          busy;
    logic          done;
    logic [6:0]    sift_count;
    logic [6:0]    bad_count;

    sift_controller #(.N_QUBITS(NQ), .WORD_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .frame_valid    (frame_valid),
        .frame_ready    (frame_ready),
        .qubit          (qubit),
        .sender_bases   (sender_bases),
        .receiver_bases (receiver_bases),
        .key_data       (key_data),
        .key_valid      (key_valid),
        .key_ready      (key_ready),
        .key_last       (key_last),
        .key_nbits      (key_nbits),
        .busy           (busy),
        .done           (done),
        .sift_count     (sift_count),
        .bad_count      (bad_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [3:0] nbits;
        logic       last;
    } exp_word_t;

    exp_word_t     exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            exp_sift;
    int            exp_bad;
    logic [2*NQ-1:0] q_v;
    logic [NQ-1:0] sb_v;
    logic [NQ-1:0] rb_v;

    // Reference model: sift the stimulus and queue the expected words.
    task automatic build_model();
        logic      bits[$];
        exp_word_t w;
        int        nb;
        exp_sift = 0;
        exp_bad  = 0;
        for (int i = 0; i < NQ; i++) begin
            if (sb_v[i] == rb_v[i]) begin
                if (q_v[2*i+1] == sb_v[i]) begin
                    bits.push_back(q_v[2*i]);
                    exp_sift++;
                end else begin
                    exp_bad++;
                end
            end
        end
        nb = bits.size();
        for (int k = 0; k < nb; k += 8) begin
            w.data  = 8'h00;
            w.nbits = 4'd0;
            for (int j = 0; j < 8 && (k + j) < nb; j++) begin
                w.data[j] = bits[k+j];
                w.nbits   = w.nbits + 4'd1;
            end
            w.last = ((k + 8) >= nb);
            exp_q.push_back(w);
        end
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < 2*NQ; i++) qubit[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < NQ; i++) begin
            sender_bases[i]   = 1'($urandom_range(0, 1));
            receiver_bases[i] = 1'($urandom_range(0, 1));
        end
    endtask

    // Frame with every position sifted; random bases and key bits.
    task automatic make_all_sifted();
        for (int i = 0; i < NQ; i++) begin
            sb_v[i]     = 1'($urandom_range(0, 1));
            rb_v[i]     = sb_v[i];
            q_v[2*i+1]  = sb_v[i];
            q_v[2*i]    = 1'($urandom_range(0, 1));
        end
    endtask

    // Accepts one frame, then runs cycle by cycle (c = cycles after accept)
    // until done, checking every handed-over word against the scoreboard.
    task automatic run_frame(input bit hold20, input bit rnd_ready,
                             output int done_at, output int first_kv,
                             output int last_hs, output int words);
        exp_word_t   w;
        bit          seen;
        bit          holding;
        logic [12:0] held;
        done_at  = -1;
        first_kv = -1;
        last_hs  = -1;
        words    = 0;
        seen     = 1'b0;
        holding  = 1'b0;
        held     = 13'd0;
        build_model();
        n_checks++;
        if (frame_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_ready_before_accept: got %b, expected 1", frame_ready);
        end
        qubit          = q_v;
        sender_bases   = sb_v;
        receiver_bases = rb_v;
        key_ready      = 1'b1;
        frame_valid    = 1'b1;
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
        scramble_inputs();
        n_checks++;
        if ({busy, frame_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL busy_after_accept: got busy=%b ready=%b, expected busy=1 ready=0", busy, frame_ready);
        end
        for (int c = 1; c <= 400 && done_at < 0; c++) begin
            if (key_valid && !seen) begin
                seen     = 1'b1;
                first_kv = c;
            end
            if (hold20 && seen && (c < first_kv + 20)) key_ready = 1'b0;
            else if (rnd_ready) key_ready = 1'($urandom_range(0, 1));
            else key_ready = 1'b1;
            if (key_valid && !key_ready) begin
                if (holding) begin
                    n_checks++;
                    if ({key_data, key_nbits, key_last} !== held) begin
                        n_fail++;
                        $display("FAIL hold_stable: got %h, expected %h at cycle %0d",
                                 {key_data, key_nbits, key_last}, held, c);
                    end
                end else begin
                    held    = {key_data, key_nbits, key_last};
                    holding = 1'b1;
                end
            end else begin
                holding = 1'b0;
            end
            if (key_valid && key_ready) begin
                words++;
                last_hs = c;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_word: got data=%h nbits=%0d last=%b, expected no word",
                             key_data, key_nbits, key_last);
                end else begin
                    w = exp_q.pop_front();
                    if ({key_data, key_nbits, key_last} !== {w.data, w.nbits, w.last}) begin
                        n_fail++;
                        $display("FAIL key_word: got data=%h nbits=%0d last=%b, expected data=%h nbits=%0d last=%b",
                                 key_data, key_nbits, key_last, w.data, w.nbits, w.last);
                    end
                end
            end
            if (done) done_at = c;
            else begin
                @(posedge clk);
                #1;
            end
        end
        n_checks++;
        if (done_at < 0) begin
            n_fail++;
            $display("FAIL done_timeout: got no done within 400 cycles, expected done");
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_words: got %0d words short, expected 0", exp_q.size());
        end
        exp_q.delete();
        n_checks++;
        if ({sift_count, bad_count} !== {7'(exp_sift), 7'(exp_bad)}) begin
            n_fail++;
            $display("FAIL counts: got sift=%0d bad=%0d, expected sift=%0d bad=%0d",
                     sift_count, bad_count, exp_sift, exp_bad);
        end
        key_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        frame_valid = 1'b0;
        key_ready   = 1'b1;
        qubit          = '0;
        sender_bases   = '0;
        receiver_bases = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({frame_ready, key_valid, key_last, key_data, key_nbits, busy, done, sift_count, bad_count}
                !== {1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 7'd0, 7'd0}) begin
            n_fail++;
            $display("FAIL reset_values: got ready=%b kv=%b kl=%b kd=%h nb=%0d busy=%b done=%b sc=%0d bc=%0d, expected 1 0 0 00 0 0 0 0 0",
                     frame_ready, key_valid, key_last, key_data, key_nbits, busy, done, sift_count, bad_count);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_all_zero();
        int d, f, l, nw;
        q_v  = '0;
        sb_v = '0;
        rb_v = '0;
        run_frame(1'b0, 1'b0, d, f, l, nw);
        n_checks++;
        if ({d, f, l, nw} !== {32'd82, 32'd9, 32'd81, 32'd10}) begin
            n_fail++;
            $display("FAIL all_zero_timing: got done=%0d first=%0d last=%0d words=%0d, expected 82 9 81 10", d, f, l, nw);
        end
        n_checks++;
        if (frame_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_at_done: got %b, expected 1", frame_ready);
        end
    endtask

    task automatic test_no_match();
        int d, f, l, nw;
        for (int i = 0; i < 2*NQ; i++) q_v[i] = 1'($urandom_range(0, 1));
        sb_v = '0;
        rb_v = '1;
        run_frame(1'b0, 1'b0, d, f, l, nw);
        n_checks++;
        if ({d, nw, sift_count} !== {32'd81, 32'd0, 7'd0}) begin
            n_fail++;
            $display("FAIL no_match: got done=%0d words=%0d sift=%0d, expected 81 0 0", d, nw, sift_count);
        end
    endtask

    task automatic test_partial_word();
        int d, f, l, nw;
        for (int i = 0; i < NQ; i++) q_v[2*i +: 2] = 2'b01;
        sb_v = '0;
        rb_v = '1;
        for (int i = 0; i <= 10; i++) rb_v[i] = 1'b0;
        run_frame(1'b0, 1'b0, d, f, l, nw);
        n_checks++;
        if ({d, f, nw, sift_count} !== {32'd83, 32'd9, 32'd2, 7'd11}) begin
            n_fail++;
            $display("FAIL partial_word: got done=%0d first=%0d words=%0d sift=%0d, expected 83 9 2 11",
                     d, f, nw, sift_count);
        end
    endtask

    task automatic test_all_bad();
        int d, f, l, nw;
        for (int i = 0; i < NQ; i++) q_v[2*i +: 2] = 2'b10;
        sb_v = '0;
        rb_v = '0;
        run_frame(1'b0, 1'b0, d, f, l, nw);
        n_checks++;
        if ({d, nw, sift_count, bad_count} !== {32'd81, 32'd0, 7'd0, 7'd80}) begin
            n_fail++;
            $display("FAIL all_bad: got done=%0d words=%0d sift=%0d bad=%0d, expected 81 0 0 80",
                     d, nw, sift_count, bad_count);
        end
    endtask

    task automatic test_backpressure();
        int d, f, l, nw;
        make_all_sifted();
        run_frame(1'b1, 1'b0, d, f, l, nw);
        n_checks++;
        if ({d, f, nw} !== {32'd102, 32'd9, 32'd10}) begin
            n_fail++;
            $display("FAIL backpressure: got done=%0d first=%0d words=%0d, expected 102 9 10", d, f, nw);
        end
    endtask

    task automatic test_midframe_reset();
        int d, f, l, nw;
        make_all_sifted();
        qubit          = q_v;
        sender_bases   = sb_v;
        receiver_bases = rb_v;
        key_ready      = 1'b1;
        frame_valid    = 1'b1;
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
        repeat (39) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if ({frame_ready, key_valid, key_last, key_data, key_nbits, busy, done, sift_count, bad_count}
                !== {1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 7'd0, 7'd0}) begin
            n_fail++;
            $display("FAIL midframe_reset: got ready=%b kv=%b kl=%b kd=%h nb=%0d busy=%b done=%b sc=%0d bc=%0d, expected 1 0 0 00 0 0 0 0 0",
                     frame_ready, key_valid, key_last, key_data, key_nbits, busy, done, sift_count, bad_count);
        end
        make_all_sifted();
        run_frame(1'b0, 1'b0, d, f, l, nw);
        n_checks++;
        if ({d, nw, sift_count} !== {32'd82, 32'd10, 7'd80}) begin
            n_fail++;
            $display("FAIL after_reset_frame: got done=%0d words=%0d sift=%0d, expected 82 10 80", d, nw, sift_count);
        end
    endtask

    task automatic test_random();
        int d, f, l, nw;
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 2*NQ; i++) q_v[i] = 1'($urandom_range(0, 1));
            for (int i = 0; i < NQ; i++) begin
                sb_v[i] = 1'($urandom_range(0, 1));
                rb_v[i] = 1'($urandom_range(0, 1));
            end
            // Last position always sifted so the final word carries key_last.
            rb_v[NQ-1]     = sb_v[NQ-1];
            q_v[2*NQ-1]    = sb_v[NQ-1];
            run_frame(1'b0, 1'b1, d, f, l, nw);
        end
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_no_match();
        test_partial_word();
        test_all_bad();
        test_backpressure();
        test_midframe_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
